// File: rtl/dc_fill_ctrl_if.sv
// Request/response and memory-side bus of the D-cache fill controller.
// master = load/store requester that also plays the memory; slave = dc_fill_ctrl.
interface dc_fill_ctrl_if;
   logic         req_valid;
   logic         req_ready;
   logic         req_wr;
   logic [31:0]  req_addr;
   logic [1:0]   req_size;
   logic [31:0]  req_wdata;
   logic         rsp_valid;
   logic         rsp_way;
   logic [3:0]   rsp_offset;
   logic         mem_rd_req;
   logic [31:0]  mem_rd_addr;
   logic         mem_rd_ack;
   logic [127:0] mem_rd_data;
   logic         mem_wr_req;
   logic [31:0]  mem_wr_addr;
   logic [1:0]   mem_wr_size;
   logic [31:0]  mem_wr_data;
   logic         mem_wr_ack;

   modport master (
      output req_valid, req_wr, req_addr, req_size, req_wdata,
      output mem_rd_ack, mem_rd_data, mem_wr_ack,
      input  req_ready, rsp_valid, rsp_way, rsp_offset,
      input  mem_rd_req, mem_rd_addr, mem_wr_req, mem_wr_addr, mem_wr_size, mem_wr_data
   );

   modport slave (
      input  req_valid, req_wr, req_addr, req_size, req_wdata,
      input  mem_rd_ack, mem_rd_data, mem_wr_ack,
      output req_ready, rsp_valid, rsp_way, rsp_offset,
      output mem_rd_req, mem_rd_addr, mem_wr_req, mem_wr_addr, mem_wr_size, mem_wr_data
   );
endinterface

// File: rtl/dc_fill_ctrl.sv
// Lookup / miss-fill / write-through store controller for a 2-way, 16-set, 16-byte-line D-cache.
// Optional macro DC_WRITE_ALLOCATE_EN: store misses allocate (fill, replay, write) instead of bypassing.
module dc_fill_ctrl (
   input  logic                 clk,
   input  logic                 rst_n,
   dc_fill_ctrl_if.slave        bus,
   output logic [3:0]           dc_index,
   output logic [15:0]          dc_wr_mask_way1,
   output logic [15:0]          dc_wr_mask_way2,
   output logic [127:0]         dc_write_data
);

`ifdef DC_WRITE_ALLOCATE_EN
   localparam bit WRITE_ALLOCATE = 1'b1;
`else
   localparam bit WRITE_ALLOCATE = 1'b0;
`endif

   typedef enum logic [2:0] {IDLE, LOOKUP, FILL, WRFILL, WRMEM} state_t;

   state_t        state;
   state_t        state_nxt;

   logic [31:0]   addr_q;
   logic [1:0]    size_q;
   logic          wr_q;
   logic [31:0]   wdata_q;
   logic          hit_q;
   logic          hit_way_q;

   logic [23:0]   tag1 [16];
   logic [23:0]   tag2 [16];
   logic [15:0]   valid1;
   logic [15:0]   valid2;
   logic [15:0]   lru;

   logic [3:0]    cur_idx;
   logic          victim;

   logic [31:0]   la_addr;
   logic          la_wr;
   logic [1:0]    la_size;
   logic [31:0]   la_wdata;
   logic [3:0]    la_idx;
   logic          la_hit1;
   logic          la_hit2;
   logic          la_hit;
   logic          la_way;

   logic [3:0]    index_nxt;
   logic [15:0]   mask1_nxt;
   logic [15:0]   mask2_nxt;
   logic [127:0]  wdata_nxt;

   // Illegal size 2 is widened to a full word.
   function automatic logic [1:0] last_byte(input logic [1:0] size);
      return (size == 2'd2) ? 2'd3 : size;
   endfunction

   function automatic logic [15:0] store_mask(input logic [3:0] off, input logic [1:0] size);
      logic [15:0] m;
      logic [4:0]  pos;
      m = 16'hFFFF;
      for (int k = 0; k < 4; k++) begin
         pos = {1'b0, off} + 5'(k);
         if ((2'(k) <= last_byte(size)) && !pos[4]) m[pos[3:0]] = 1'b0;
      end
      return m;
   endfunction

   function automatic logic [127:0] store_data(input logic [3:0] off, input logic [1:0] size,
                                               input logic [31:0] wd);
      logic [127:0] d;
      logic [4:0]   pos;
      d = '0;
      for (int k = 0; k < 4; k++) begin
         pos = {1'b0, off} + 5'(k);
         if ((2'(k) <= last_byte(size)) && !pos[4]) d[pos[3:0]*8 +: 8] = wd[k*8 +: 8];
      end
      return d;
   endfunction

   assign cur_idx = addr_q[7:4];

   // First invalid way wins (way1 preferred), otherwise the LRU way.
   always_comb begin
      if (!valid1[cur_idx])      victim = 1'b0;
      else if (!valid2[cur_idx]) victim = 1'b1;
      else                       victim = lru[cur_idx];
   end

   // Lookahead for the cycle about to enter LOOKUP, so the array-write
   // controls can be registered and stable for the whole LOOKUP cycle.
   always_comb begin
      la_addr  = addr_q;
      la_wr    = wr_q;
      la_size  = size_q;
      la_wdata = wdata_q;
      if (state == IDLE) begin
         la_addr  = bus.req_addr;
         la_wr    = bus.req_wr;
         la_size  = bus.req_size;
         la_wdata = bus.req_wdata;
      end
   end

   assign la_idx  = la_addr[7:4];
   assign la_hit1 = valid1[la_idx] && (tag1[la_idx] == la_addr[31:8]);
   assign la_hit2 = valid2[la_idx] && (tag2[la_idx] == la_addr[31:8]);

   // A replay from WRFILL hits the way just filled; tags are not yet visible.
   always_comb begin
      if (state == WRFILL) begin
         la_hit = 1'b1;
         la_way = victim;
      end else begin
         la_hit = la_hit1 || la_hit2;
         la_way = la_hit2 && !la_hit1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (bus.req_valid) state_nxt = LOOKUP;
         LOOKUP: begin
            if (hit_q)                         state_nxt = wr_q ? WRMEM : IDLE;
            else if (!wr_q || WRITE_ALLOCATE)  state_nxt = FILL;
            else                               state_nxt = WRMEM;
         end
         FILL:    if (bus.mem_rd_ack) state_nxt = WRFILL;
         WRFILL:  state_nxt = LOOKUP;
         WRMEM:   if (bus.mem_wr_ack) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready   = (state == IDLE);
      bus.rsp_valid   = (state == LOOKUP) && hit_q && !wr_q;
      bus.rsp_way     = hit_way_q;
      bus.rsp_offset  = addr_q[3:0];
      bus.mem_rd_req  = (state == FILL);
      bus.mem_rd_addr = {addr_q[31:4], 4'h0};
      bus.mem_wr_req  = (state == WRMEM);
      bus.mem_wr_addr = addr_q;
      bus.mem_wr_size = size_q;
      bus.mem_wr_data = wdata_q;

      index_nxt = dc_index;
      mask1_nxt = 16'hFFFF;
      mask2_nxt = 16'hFFFF;
      wdata_nxt = dc_write_data;
      if (state == IDLE && bus.req_valid) index_nxt = bus.req_addr[7:4];
      if (state_nxt == WRFILL) begin
         if (victim) mask2_nxt = 16'h0000;
         else        mask1_nxt = 16'h0000;
         wdata_nxt = bus.mem_rd_data;
      end else if (state_nxt == LOOKUP && la_wr && la_hit) begin
         if (la_way) mask2_nxt = store_mask(la_addr[3:0], la_size);
         else        mask1_nxt = store_mask(la_addr[3:0], la_size);
         wdata_nxt = store_data(la_addr[3:0], la_size, la_wdata);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q          <= '0;
         size_q          <= '0;
         wr_q            <= 1'b0;
         wdata_q         <= '0;
         hit_q           <= 1'b0;
         hit_way_q       <= 1'b0;
         dc_index        <= '0;
         dc_wr_mask_way1 <= 16'hFFFF;
         dc_wr_mask_way2 <= 16'hFFFF;
         dc_write_data   <= '0;
         valid1          <= '0;
         valid2          <= '0;
         lru             <= '0;
      end else begin
         if (state == IDLE && bus.req_valid) begin
            addr_q  <= bus.req_addr;
            size_q  <= bus.req_size;
            wr_q    <= bus.req_wr;
            wdata_q <= bus.req_wdata;
         end
         if (state_nxt == LOOKUP) begin
            hit_q     <= la_hit;
            hit_way_q <= la_way;
         end
         dc_index        <= index_nxt;
         dc_wr_mask_way1 <= mask1_nxt;
         dc_wr_mask_way2 <= mask2_nxt;
         dc_write_data   <= wdata_nxt;
         if (state == LOOKUP && hit_q) begin
            lru[cur_idx] <= ~hit_way_q;
         end else if (state == WRFILL) begin
            if (victim) valid2[cur_idx] <= 1'b1;
            else        valid1[cur_idx] <= 1'b1;
            lru[cur_idx] <= ~victim;
         end
      end
   end

   // Tags need no reset: they are only trusted where the valid bit is set.
   always_ff @(posedge clk) begin
      if (state == WRFILL) begin
         if (victim) tag2[cur_idx] <= addr_q[31:8];
         else        tag1[cur_idx] <= addr_q[31:8];
      end
   end

endmodule

// File: tb/tb_dc_fill_ctrl.sv
// Directed bench for dc_fill_ctrl: fills, hits, LRU replacement, store masks, write-through, reset abort.
module tb_dc_fill_ctrl;
   logic clk;
   logic rst_n;
   logic [3:0]   dc_index;
   logic [15:0]  dc_wr_mask_way1;
   logic [15:0]  dc_wr_mask_way2;
   logic [127:0] dc_write_data;
   int errors;
   int checks;

   dc_fill_ctrl_if bus();

   dc_fill_ctrl dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .bus             (bus),
      .dc_index        (dc_index),
      .dc_wr_mask_way1 (dc_wr_mask_way1),
      .dc_wr_mask_way2 (dc_wr_mask_way2),
      .dc_write_data   (dc_write_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic load_miss(input string tag, input logic [31:0] a, input logic [127:0] line,
                            input logic way, input int hold);
      bus.req_valid = 1'b1; bus.req_wr = 1'b0; bus.req_addr = a; bus.req_size = 2'd3;
      chk({tag, "/ready"}, 128'(bus.req_ready), 128'(1));
      step();
      bus.req_valid = 1'b0;
      chk({tag, "/lookup_rsp"}, 128'(bus.rsp_valid), 128'(0));
      chk({tag, "/index"}, 128'(dc_index), 128'(a[7:4]));
      step();
      chk({tag, "/rd_req"}, 128'(bus.mem_rd_req), 128'(1));
      chk({tag, "/rd_addr"}, 128'(bus.mem_rd_addr), 128'({a[31:4], 4'h0}));
      for (int i = 0; i < hold; i++) begin
         step();
         chk({tag, "/rd_req_held"}, 128'(bus.mem_rd_req), 128'(1));
      end
      bus.mem_rd_ack = 1'b1; bus.mem_rd_data = line;
      step();
      bus.mem_rd_ack = 1'b0;
      chk({tag, "/fill_masks"}, 128'({dc_wr_mask_way2, dc_wr_mask_way1}),
          way ? 128'h0000_FFFF : 128'hFFFF_0000);
      chk({tag, "/fill_data"}, dc_write_data, line);
      step();
      chk({tag, "/rsp_valid"}, 128'(bus.rsp_valid), 128'(1));
      chk({tag, "/rsp_way"}, 128'(bus.rsp_way), 128'(way));
      chk({tag, "/rsp_offset"}, 128'(bus.rsp_offset), 128'(a[3:0]));
      chk({tag, "/idle_masks"}, 128'({dc_wr_mask_way2, dc_wr_mask_way1}), 128'hFFFF_FFFF);
      step();
      chk({tag, "/back_idle"}, 128'({bus.req_ready, bus.rsp_valid}), 128'b10);
   endtask

   task automatic load_hit(input string tag, input logic [31:0] a, input logic way);
      bus.req_valid = 1'b1; bus.req_wr = 1'b0; bus.req_addr = a; bus.req_size = 2'd0;
      step();
      bus.req_valid = 1'b0;
      chk({tag, "/rsp_valid"}, 128'(bus.rsp_valid), 128'(1));
      chk({tag, "/rsp_way"}, 128'(bus.rsp_way), 128'(way));
      chk({tag, "/rsp_offset"}, 128'(bus.rsp_offset), 128'(a[3:0]));
      step();
      chk({tag, "/no_fill"}, 128'({bus.mem_rd_req, bus.rsp_valid, bus.req_ready}), 128'b001);
   endtask

   task automatic store_req(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
      bus.req_valid = 1'b1; bus.req_wr = 1'b1; bus.req_addr = a; bus.req_size = sz;
      bus.req_wdata = wd;
      step();
      bus.req_valid = 1'b0; bus.req_wr = 1'b0;
   endtask

   task automatic store_finish(input string tag, input logic [31:0] a, input logic [1:0] sz,
                               input logic [31:0] wd, input int hold);
      step();
      chk({tag, "/wr_req"}, 128'(bus.mem_wr_req), 128'(1));
      chk({tag, "/wr_addr"}, 128'(bus.mem_wr_addr), 128'(a));
      chk({tag, "/wr_size"}, 128'(bus.mem_wr_size), 128'(sz));
      chk({tag, "/wr_data"}, 128'(bus.mem_wr_data), 128'(wd));
      chk({tag, "/wrmem_masks"}, 128'({dc_wr_mask_way2, dc_wr_mask_way1}), 128'hFFFF_FFFF);
      for (int i = 0; i < hold; i++) begin
         step();
         chk({tag, "/wr_req_held"}, 128'(bus.mem_wr_req), 128'(1));
      end
      bus.mem_wr_ack = 1'b1;
      step();
      bus.mem_wr_ack = 1'b0;
      chk({tag, "/wr_done"}, 128'({bus.mem_wr_req, bus.req_ready}), 128'b01);
   endtask

   localparam logic [127:0] LINE_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
   localparam logic [127:0] LINE_B = 128'hB0B1B2B3_B4B5B6B7_B8B9BABB_BCBDBEBF;
   localparam logic [127:0] LINE_C = 128'hC0C1C2C3_C4C5C6C7_C8C9CACB_CCCDCECF;
   localparam logic [127:0] LINE_F = 128'hF0F1F2F3_F4F5F6F7_F8F9FAFB_FCFDFEFF;

   initial begin
      errors = 0;
      checks = 0;
      rst_n = 1'b0;
      bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_addr = '0; bus.req_size = '0;
      bus.req_wdata = '0; bus.mem_rd_ack = 1'b0; bus.mem_rd_data = '0; bus.mem_wr_ack = 1'b0;
      step();
      step();
      chk("rst/ready", 128'(bus.req_ready), 128'(1));
      chk("rst/rsp", 128'({bus.rsp_valid, bus.rsp_way, bus.rsp_offset}), 128'(0));
      chk("rst/index", 128'(dc_index), 128'(0));
      chk("rst/masks", 128'({dc_wr_mask_way2, dc_wr_mask_way1}), 128'hFFFF_FFFF);
      chk("rst/wdata", dc_write_data, 128'(0));
      chk("rst/mem_req", 128'({bus.mem_rd_req, bus.mem_wr_req}), 128'(0));
      chk("rst/mem_addr", 128'({bus.mem_rd_addr, bus.mem_wr_addr, bus.mem_wr_data}), 128'(0));
      rst_n = 1'b1;
      step();

      load_miss("missA", 32'h0000_0120, LINE_A, 1'b0, 2);
      load_hit("hitA", 32'h0000_0128, 1'b0);

      store_req(32'h0000_0124, 2'd3, 32'hAABBCCDD);
      chk("st124/mask1", 128'(dc_wr_mask_way1), 128'hFF0F);
      chk("st124/mask2", 128'(dc_wr_mask_way2), 128'hFFFF);
      chk("st124/data", 128'(dc_write_data[63:32]), 128'hAABBCCDD);
      chk("st124/no_rsp", 128'({bus.rsp_valid, bus.mem_wr_req}), 128'(0));
      store_finish("st124", 32'h0000_0124, 2'd3, 32'hAABBCCDD, 2);

      store_req(32'h0000_012F, 2'd1, 32'h0000_1234);
      chk("st12F/mask1", 128'(dc_wr_mask_way1), 128'h7FFF);
      chk("st12F/data", 128'(dc_write_data[127:120]), 128'h34);
      store_finish("st12F", 32'h0000_012F, 2'd1, 32'h0000_1234, 0);

      store_req(32'h0000_0128, 2'd2, 32'h11223344);
      chk("st128/mask1", 128'(dc_wr_mask_way1), 128'hF0FF);
      chk("st128/data", 128'(dc_write_data[95:64]), 128'h11223344);
      store_finish("st128", 32'h0000_0128, 2'd2, 32'h11223344, 0);

      load_miss("missB", 32'h0000_0220, LINE_B, 1'b1, 0);
      load_miss("missC", 32'h0000_0320, LINE_C, 1'b0, 0);
      load_hit("hitB", 32'h0000_0224, 1'b1);
      load_miss("reloadA", 32'h0000_0120, LINE_A, 1'b0, 0);

      store_req(32'h0000_0F00, 2'd3, 32'h55667788);
      chk("stF00/lookup_masks", 128'({dc_wr_mask_way2, dc_wr_mask_way1}), 128'hFFFF_FFFF);
`ifdef DC_WRITE_ALLOCATE_EN
      step();
      chk("stF00/rd_req", 128'(bus.mem_rd_req), 128'(1));
      bus.mem_rd_ack = 1'b1; bus.mem_rd_data = LINE_F;
      step();
      bus.mem_rd_ack = 1'b0;
      chk("stF00/fill_mask1", 128'(dc_wr_mask_way1), 128'h0000);
      step();
      chk("stF00/write_mask1", 128'(dc_wr_mask_way1), 128'hFFF0);
      chk("stF00/write_data", 128'(dc_write_data[31:0]), 128'h55667788);
      store_finish("stF00", 32'h0000_0F00, 2'd3, 32'h55667788, 1);
      load_hit("hitF00", 32'h0000_0F04, 1'b0);
`else
      chk("stF00/no_fill", 128'(bus.mem_rd_req), 128'(0));
      store_finish("stF00", 32'h0000_0F00, 2'd3, 32'h55667788, 1);
      load_miss("missF00", 32'h0000_0F04, LINE_F, 1'b0, 0);
`endif

      bus.req_valid = 1'b1; bus.req_wr = 1'b0; bus.req_addr = 32'h0000_0530; bus.req_size = 2'd3;
      step();
      bus.req_valid = 1'b0;
      step();
      chk("rstfill/in_fill", 128'(bus.mem_rd_req), 128'(1));
      rst_n = 1'b0;
      #1;
      chk("rstfill/abort", 128'({bus.mem_rd_req, bus.req_ready}), 128'b01);
      step();
      rst_n = 1'b1;
      chk("rstfill/index", 128'(dc_index), 128'(0));
      bus.mem_rd_ack = 1'b1; bus.mem_rd_data = LINE_C;
      step();
      bus.mem_rd_ack = 1'b0;
      chk("rstfill/late_ack_masks", 128'({dc_wr_mask_way2, dc_wr_mask_way1}), 128'hFFFF_FFFF);
      chk("rstfill/late_ack_idle", 128'({bus.req_ready, bus.mem_rd_req, bus.rsp_valid}), 128'b100);
      load_miss("postrst", 32'h0000_0120, LINE_A, 1'b0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
